// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access pipeline stage: memory opcodes,
// access sizes and the stage status record passed between stages.
package memory_access_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_t;

  typedef struct packed {
    mem_op_t    mem_op;
    mem_size_t  mem_size;
    logic       mem_sign;
    logic [1:0] reg_rd_src;
  } instr_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [31:0] data;
  } data_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    instr_t      instruction;
    data_t       data;
    logic [31:0] reg_rd1;
    logic [31:0] reg_rd2;
  } stage_status_t;

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/response bus between the memory-access stage
// (master) and the data memory (slave).
interface memory_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues aligned loads/stores on the data bus,
// extracts/extends load data and passes non-memory results straight through.
module memory_access
  import memory_access_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  stage_status_t          stage_in,
  output stage_status_t          stage_out,
  output logic                   misaligned,
  memory_access_if.master        dmem
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        misaligned_q, misaligned_d;
  logic        req_s;
  logic        is_mem_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        mis_s;
  logic [1:0]  off_s;
  logic        unused_ready;

  function automatic logic [3:0] f_be(input mem_size_t size, input logic [1:0] off);
    case (size)
      SIZE_B:  f_be = 4'b0001 << off;
      SIZE_H:  f_be = off[1] ? 4'b1100 : 4'b0011;
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input mem_size_t size, input logic [31:0] d);
    case (size)
      SIZE_B:  f_wdata = {4{d[7:0]}};
      SIZE_H:  f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input mem_size_t size, input logic sign,
                                         input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      SIZE_B:  f_load = {{24{sign & sh[7]}}, sh[7:0]};
      SIZE_H:  f_load = {{16{sign & sh[15]}}, sh[15:0]};
      default: f_load = sh;
    endcase
  endfunction

  function automatic logic f_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      SIZE_H:  f_misaligned = off[0];
      SIZE_W:  f_misaligned = (off != 2'b00);
      default: f_misaligned = 1'b0;
    endcase
  endfunction

  assign unused_ready = stage_in.ready;
  assign off_s      = stage_in.data.data[1:0];
  assign is_load_s  = (stage_in.instruction.mem_op == MEM_LOAD);
  assign is_store_s = (stage_in.instruction.mem_op == MEM_STORE);
  assign is_mem_s   = stage_in.valid & (is_load_s | is_store_s);
  assign mis_s      = f_misaligned(stage_in.instruction.mem_size, off_s);

  // Lanes come straight from stage_in, which upstream holds while ready is low.
  assign dmem.req   = req_s & rst_n;
  assign dmem.we    = is_store_s;
  assign dmem.addr  = {stage_in.data.data[31:2], 2'b00};
  assign dmem.be    = f_be(stage_in.instruction.mem_size, off_s);
  assign dmem.wdata = f_wdata(stage_in.instruction.mem_size, stage_in.reg_rd2);
  assign misaligned = misaligned_q;

  // Next-state, bus request and stage output decode.
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    misaligned_d = misaligned_q;
    req_s        = 1'b0;
    stage_out    = stage_in;
    stage_out.valid = 1'b0;
    stage_out.ready = 1'b0;
    stage_out.data.address = stage_in.valid ? stage_in.data.address : 32'd0;
    if (is_load_s) begin
      stage_out.data.data  = result_q;
      stage_out.data.valid = 1'b0;
    end else if (is_store_s) begin
      stage_out.data.valid = 1'b0;
    end else begin
      stage_out.data.valid = stage_in.data.valid;
    end

    case (state_q)
      IDLE: begin
        if (is_mem_s) begin
          if (mis_s) begin
            misaligned_d = 1'b1;
            state_d      = DONE;
          end else begin
            req_s = 1'b1;
            if (dmem.gnt) begin
              state_d = is_store_s ? DONE : RESP;
            end else begin
              state_d = REQ;
            end
          end
        end else begin
          stage_out.valid = stage_in.valid;
          stage_out.ready = 1'b1;
        end
      end
      REQ: begin
        // Held regardless of stage_in.valid: there is no way to retract a request.
        req_s = 1'b1;
        if (dmem.gnt) begin
          state_d = is_store_s ? DONE : RESP;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (dmem.rvalid) begin
          result_d = f_load(stage_in.instruction.mem_size, stage_in.instruction.mem_sign,
                            off_s, dmem.rdata);
          state_d  = DONE;
        end else begin
          state_d = RESP;
        end
      end
      DONE: begin
        stage_out.valid      = 1'b1;
        stage_out.ready      = 1'b1;
        stage_out.data.valid = is_load_s & ~misaligned_q;
        misaligned_d         = 1'b0;
        state_d              = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, load result and misaligned flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      result_q     <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scenario bench for memory_access: load results are queued when read data
// is driven and popped when the stage reports completion.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  stage_status_t si;
  stage_status_t so;
  logic          misaligned;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   exp_v;

  memory_access_if dmem_bus();

  memory_access dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stage_in   (si),
    .stage_out  (so),
    .misaligned (misaligned),
    .dmem       (dmem_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_be(input mem_size_t s, input logic [1:0] o);
    if (s == SIZE_B) begin
      case (o)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end else if (s == SIZE_H) begin
      return o[1] ? 4'b1100 : 4'b0011;
    end
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input mem_size_t s, input logic [31:0] d);
    if (s == SIZE_B) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (s == SIZE_H) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input mem_size_t s, input logic sg,
                                         input logic [1:0] o, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{o, 3'b000} +: 8];
    h = o[1] ? rd[31:16] : rd[15:0];
    if (s == SIZE_B) return (sg && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
    if (s == SIZE_H) return (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
    return rd;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input mem_op_t op, input mem_size_t sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] rs2);
    si.valid                  = 1'b1;
    si.ready                  = 1'b0;
    si.pc                     = 32'h0000_0400;
    si.instruction.mem_op     = op;
    si.instruction.mem_size   = sz;
    si.instruction.mem_sign   = sg;
    si.instruction.reg_rd_src = 2'd1;
    si.data.valid             = 1'b1;
    si.data.address           = 32'd7;
    si.data.data              = addr;
    si.reg_rd1                = 32'h0;
    si.reg_rd2                = rs2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    si = '0;
    dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata = 32'h0;
    #3;
    n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", dmem_bus.req); end
    n_cmp++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL rst_mis: got %b want 0", misaligned); end
    n_cmp++; if (so.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", so.valid); end
    n_cmp++; if (so.ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", so.ready); end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    set_op(MEM_NONE, SIZE_W, 1'b0, 32'h0000_1234, 32'h0);
    si.pc = 32'h0000_0080;
    si.data.address = 32'd5;
    #1;
    n_cmp++; if (so.valid !== 1'b1) begin n_err++; $display("FAIL pt_valid: got %b want 1", so.valid); end
    n_cmp++; if (so.data.data !== 32'h0000_1234) begin n_err++; $display("FAIL pt_data: got %h want 00001234", so.data.data); end
    n_cmp++; if (so.ready !== 1'b1) begin n_err++; $display("FAIL pt_ready: got %b want 1", so.ready); end
    n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL pt_req: got %b want 0", dmem_bus.req); end
    n_cmp++; if (so.pc !== 32'h0000_0080) begin n_err++; $display("FAIL pt_pc: got %h want 00000080", so.pc); end
    n_cmp++; if (so.data.address !== 32'd5) begin n_err++; $display("FAIL pt_rd: got %h want 5", so.data.address); end
    si.valid = 1'b0;
    #1;
    n_cmp++; if (so.data.address !== 32'd0) begin n_err++; $display("FAIL pt_rd_inv: got %h want 0", so.data.address); end
    tick();
  endtask

  task automatic test_load_byte();
    set_op(MEM_LOAD, SIZE_B, 1'b1, 32'h0000_0103, 32'h0);
    dmem_bus.gnt = 1'b1;
    #1;
    n_cmp++; if (dmem_bus.req !== 1'b1) begin n_err++; $display("FAIL lb_req: got %b want 1", dmem_bus.req); end
    n_cmp++; if (dmem_bus.be !== 4'b1000) begin n_err++; $display("FAIL lb_be: got %b want 1000", dmem_bus.be); end
    n_cmp++; if (dmem_bus.addr !== 32'h0000_0100) begin n_err++; $display("FAIL lb_addr: got %h want 00000100", dmem_bus.addr); end
    n_cmp++; if (dmem_bus.we !== 1'b0) begin n_err++; $display("FAIL lb_we: got %b want 0", dmem_bus.we); end
    n_cmp++; if (so.ready !== 1'b0) begin n_err++; $display("FAIL lb_ready0: got %b want 0", so.ready); end
    tick();
    dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata = 32'h80FF_FF00;
    exp_q.push_back(32'hFFFF_FF80);
    #1;
    n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL lb_resp_req: got %b want 0", dmem_bus.req); end
    n_cmp++; if (so.valid !== 1'b0) begin n_err++; $display("FAIL lb_resp_valid: got %b want 0", so.valid); end
    tick();
    dmem_bus.rvalid = 1'b0;
    #1;
    n_cmp++; if (so.valid !== 1'b1) begin n_err++; $display("FAIL lb_done_valid: got %b want 1", so.valid); end
    n_cmp++; if (so.data.valid !== 1'b1) begin n_err++; $display("FAIL lb_dvalid: got %b want 1", so.data.valid); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL lb_data: got %h want queued value, queue empty", so.data.data); end
    else begin exp_v = exp_q.pop_front(); if (so.data.data !== exp_v) begin n_err++; $display("FAIL lb_data: got %h want %h", so.data.data, exp_v); end end
    si.valid = 1'b0;
    tick();
  endtask

  task automatic test_store_half();
    set_op(MEM_STORE, SIZE_H, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      dmem_bus.gnt = (i == 3);
      si.valid = !(i == 1 || i == 2);
      #1;
      n_cmp++; if (dmem_bus.req !== 1'b1) begin n_err++; $display("FAIL sh_req[%0d]: got %b want 1", i, dmem_bus.req); end
      n_cmp++; if (dmem_bus.addr !== 32'h0000_0200) begin n_err++; $display("FAIL sh_addr[%0d]: got %h want 00000200", i, dmem_bus.addr); end
      n_cmp++; if (dmem_bus.be !== 4'b1100) begin n_err++; $display("FAIL sh_be[%0d]: got %b want 1100", i, dmem_bus.be); end
      n_cmp++; if (dmem_bus.wdata !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_wdata[%0d]: got %h want beefbeef", i, dmem_bus.wdata); end
      n_cmp++; if (dmem_bus.we !== 1'b1) begin n_err++; $display("FAIL sh_we[%0d]: got %b want 1", i, dmem_bus.we); end
      n_cmp++; if (so.ready !== 1'b0) begin n_err++; $display("FAIL sh_ready[%0d]: got %b want 0", i, so.ready); end
      tick();
    end
    dmem_bus.gnt = 1'b0;
    #1;
    n_cmp++; if (so.valid !== 1'b1) begin n_err++; $display("FAIL sh_done_valid: got %b want 1", so.valid); end
    n_cmp++; if (so.ready !== 1'b1) begin n_err++; $display("FAIL sh_done_ready: got %b want 1", so.ready); end
    n_cmp++; if (so.data.valid !== 1'b0) begin n_err++; $display("FAIL sh_dvalid: got %b want 0", so.data.valid); end
    n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL sh_done_req: got %b want 0", dmem_bus.req); end
    si.valid = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    set_op(MEM_LOAD, SIZE_W, 1'b0, 32'h0000_0105, 32'h0);
    #1;
    n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL mis_req: got %b want 0", dmem_bus.req); end
    n_cmp++; if (so.valid !== 1'b0) begin n_err++; $display("FAIL mis_valid0: got %b want 0", so.valid); end
    tick();
    n_cmp++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b want 1", misaligned); end
    n_cmp++; if (so.valid !== 1'b1) begin n_err++; $display("FAIL mis_valid: got %b want 1", so.valid); end
    n_cmp++; if (so.data.valid !== 1'b0) begin n_err++; $display("FAIL mis_dvalid: got %b want 0", so.data.valid); end
    n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL mis_req1: got %b want 0", dmem_bus.req); end
    si.valid = 1'b0;
    tick();
    n_cmp++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b want 0", misaligned); end
  endtask

  task automatic test_load_hu();
    set_op(MEM_LOAD, SIZE_H, 1'b0, 32'h0000_0040, 32'h0);
    dmem_bus.gnt = 1'b1;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (dmem_bus.be !== 4'b0011) begin n_err++; $display("FAIL lhu_be: got %b want 0011", dmem_bus.be); end
    tick();
    dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (so.valid !== 1'b0) begin n_err++; $display("FAIL lhu_wait_valid[%0d]: got %b want 0", i, so.valid); end
      n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL lhu_wait_req[%0d]: got %b want 0", i, dmem_bus.req); end
      tick();
    end
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata = 32'h0000_9ABC;
    exp_q.push_back(32'h0000_9ABC);
    tick();
    dmem_bus.rvalid = 1'b0;
    #1;
    n_cmp++; if (so.valid !== 1'b1) begin n_err++; $display("FAIL lhu_valid: got %b want 1", so.valid); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL lhu_data: got %h want queued value, queue empty", so.data.data); end
    else begin exp_v = exp_q.pop_front(); if (so.data.data !== exp_v) begin n_err++; $display("FAIL lhu_data: got %h want %h", so.data.data, exp_v); end end
    si.valid = 1'b0;
    tick();
  endtask

  task automatic test_gnt_rvalid_same();
    set_op(MEM_LOAD, SIZE_W, 1'b1, 32'h0000_0300, 32'h0);
    dmem_bus.gnt = 1'b0;
    #1;
    n_cmp++; if (dmem_bus.req !== 1'b1) begin n_err++; $display("FAIL gr_req0: got %b want 1", dmem_bus.req); end
    tick();
    dmem_bus.gnt = 1'b1;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata = 32'hBAD0_BAD0;
    #1;
    n_cmp++; if (dmem_bus.req !== 1'b1) begin n_err++; $display("FAIL gr_req1: got %b want 1", dmem_bus.req); end
    tick();
    dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b0;
    #1;
    n_cmp++; if (so.valid !== 1'b0) begin n_err++; $display("FAIL gr_early_done: got %b want 0", so.valid); end
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata = 32'h1234_5678;
    exp_q.push_back(m_load(SIZE_W, 1'b1, 2'b00, 32'h1234_5678));
    tick();
    dmem_bus.rvalid = 1'b0;
    #1;
    n_cmp++; if (so.valid !== 1'b1) begin n_err++; $display("FAIL gr_valid: got %b want 1", so.valid); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL gr_data: got %h want queued value, queue empty", so.data.data); end
    else begin exp_v = exp_q.pop_front(); if (so.data.data !== exp_v) begin n_err++; $display("FAIL gr_data: got %h want %h", so.data.data, exp_v); end end
    si.valid = 1'b0;
    tick();
  endtask

  typedef struct {
    mem_op_t     op;
    mem_size_t   sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] rs2;
  } vec_t;

  task automatic test_back_to_back();
    vec_t        v[7];
    logic [31:0] rd;
    v[0] = '{MEM_LOAD,  SIZE_B, 1'b0, 32'h0000_1001, 32'h0};
    v[1] = '{MEM_LOAD,  SIZE_H, 1'b1, 32'h0000_1002, 32'h0};
    v[2] = '{MEM_LOAD,  SIZE_W, 1'b0, 32'h0000_1004, 32'h0};
    v[3] = '{MEM_STORE, SIZE_B, 1'b0, 32'h0000_2003, 32'h1122_3344};
    v[4] = '{MEM_STORE, SIZE_H, 1'b0, 32'h0000_2000, 32'hCAFE_F00D};
    v[5] = '{MEM_STORE, SIZE_W, 1'b0, 32'h0000_2008, 32'h0BAD_F00D};
    v[6] = '{MEM_LOAD,  SIZE_B, 1'b1, 32'h0000_1002, 32'h0};
    for (int i = 0; i < 7; i++) begin
      set_op(v[i].op, v[i].sz, v[i].sg, v[i].addr, v[i].rs2);
      dmem_bus.gnt = 1'b1;
      #1;
      n_cmp++; if (dmem_bus.be !== m_be(v[i].sz, v[i].addr[1:0])) begin n_err++; $display("FAIL b2b_be[%0d]: got %b want %b", i, dmem_bus.be, m_be(v[i].sz, v[i].addr[1:0])); end
      n_cmp++; if (dmem_bus.wdata !== m_wdata(v[i].sz, v[i].rs2)) begin n_err++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, dmem_bus.wdata, m_wdata(v[i].sz, v[i].rs2)); end
      n_cmp++; if (dmem_bus.we !== (v[i].op == MEM_STORE)) begin n_err++; $display("FAIL b2b_we[%0d]: got %b want %b", i, dmem_bus.we, (v[i].op == MEM_STORE)); end
      tick();
      dmem_bus.gnt = 1'b0;
      if (v[i].op == MEM_LOAD) begin
        rd = $urandom;
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata = rd;
        exp_q.push_back(m_load(v[i].sz, v[i].sg, v[i].addr[1:0], rd));
        tick();
        dmem_bus.rvalid = 1'b0;
      end
      #1;
      n_cmp++; if (so.valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, so.valid); end
      n_cmp++; if (so.data.valid !== (v[i].op == MEM_LOAD)) begin n_err++; $display("FAIL b2b_dvalid[%0d]: got %b want %b", i, so.data.valid, (v[i].op == MEM_LOAD)); end
      if (v[i].op == MEM_LOAD) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want queued value, queue empty", i, so.data.data); end
        else begin exp_v = exp_q.pop_front(); if (so.data.data !== exp_v) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, so.data.data, exp_v); end end
      end
      tick();
    end
    si.valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_resp();
    set_op(MEM_LOAD, SIZE_B, 1'b0, 32'h0000_0010, 32'h0);
    dmem_bus.gnt = 1'b1;
    tick();
    dmem_bus.gnt = 1'b0;
    #1;
    n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL rr_resp_req: got %b want 0", dmem_bus.req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL rr_rst_req: got %b want 0", dmem_bus.req); end
    n_cmp++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL rr_rst_mis: got %b want 0", misaligned); end
    si.valid = 1'b0;
    tick();
    rst_n = 1'b1;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata = 32'h0000_0055;
    #1;
    n_cmp++; if (so.valid !== 1'b0) begin n_err++; $display("FAIL rr_valid0: got %b want 0", so.valid); end
    tick();
    dmem_bus.rvalid = 1'b0;
    #1;
    n_cmp++; if (so.valid !== 1'b0) begin n_err++; $display("FAIL rr_valid1: got %b want 0", so.valid); end
    n_cmp++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL rr_req1: got %b want 0", dmem_bus.req); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_load_hu();
    test_gnt_rvalid_same();
    test_back_to_back();
    test_reset_mid_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
